mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed number of wait states and a one-cycle ready/err response.
// Define MEMRESP_BYTE_EN to add the 4-bit byte-enable input "be" for partial-word writes.
module mem_responder #(
  parameter int WORDS = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
`ifdef MEMRESP_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] WORDS_L = 32'(WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          we_reg;
  logic          err_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wd_reg;
  logic [3:0]    be_reg;

  logic [31:0]   mem [WORDS];
  logic [31:0]   rd_data_reg;

  logic          adr_ok;
  logic          accept;
  logic          commit;
  logic [AW-1:0] rd_idx;
  logic [3:0]    be_in;
  logic [3:0]    lane_we;

`ifdef MEMRESP_BYTE_EN
  assign be_in = be;
`else
  assign be_in = 4'hF;
`endif

  assign adr_ok = (adr[1:0] == 2'b00) && ({2'b00, adr[31:2]} < WORDS_L);
  assign accept = (state_reg == IDLE) && req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (!adr_ok || WAIT_L == 4'd0) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = WAIT_L;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Request fields are captured only on acceptance so later bus activity cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      wd_reg    <= '0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg  <= we;
        err_reg <= !adr_ok;
        idx_reg <= adr[AW+1:2];
        wd_reg  <= wd;
        be_reg  <= be_in;
      end
    end
  end

  // The write lands on the edge that closes RESP; a concurrent reset cancels it.
  assign commit = (state_reg == RESP) && we_reg && !err_reg && !reset;

  // With zero wait states the array must be read straight from the incoming address.
  assign rd_idx = (state_reg == IDLE) ? adr[AW+1:2] : idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = commit && be_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    rd_data_reg <= mem[rd_idx];
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) begin
        mem[idx_reg][8*b +: 8] <= wd_reg[8*b +: 8];
      end
    end
  end

  assign ready = (state_reg == RESP);
  assign err   = ready && err_reg;
  assign rd    = (ready && !we_reg && !err_reg) ? rd_data_reg : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a WAIT=2 instance for the vector table and reset cases,
// plus a WAIT=0 instance for back-to-back reads.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we;
  logic [31:0] adr, wd;
  logic [3:0]  be;
  logic [31:0] rd_a, rd_b;
  logic        ready_a, ready_b, err_a, err_b;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  mem_responder #(.WORDS(64), .WAIT(WAIT_A)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .adr(adr), .wd(wd),
`ifdef MEMRESP_BYTE_EN
    .be(be),
`endif
    .rd(rd_a), .ready(ready_a), .err(err_a)
  );

  mem_responder #(.WORDS(64), .WAIT(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .adr(adr), .wd(wd),
`ifdef MEMRESP_BYTE_EN
    .be(be),
`endif
    .rd(rd_b), .ready(ready_b), .err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // One request on instance a (sel=0) or b (sel=1); bus lines are scrambled while waiting.
  task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    exp_t e;
    bit   seen;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.lat = exp_err ? 0 : (sel ? 0 : WAIT_A);
    sb.push_back(e);
    @(negedge clk);
    we = w; adr = a; wd = d; be = b;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (sel ? ready_b : ready_a) begin
        seen = 1'b1;
        e = sb.pop_front();
        check({tag, " err"}, 32'(sel ? err_b : err_a), 32'(e.err));
        check({tag, " rd"}, sel ? rd_b : rd_a, e.rd);
        check({tag, " latency"}, 32'(k), 32'(e.lat));
        req_a = 1'b0; req_b = 1'b0;
      end else begin
        adr = $urandom; wd = $urandom; we = 1'($urandom_range(0, 1)); be = 4'($urandom);
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL %s timeout: got no ready required ready within 40 cycles", tag);
      void'(sb.pop_front());
      req_a = 1'b0; req_b = 1'b0;
    end
    @(negedge clk);
    check({tag, " ready single pulse"}, 32'(sel ? ready_b : ready_a), 32'd0);
    $display("txn %s we=%0d adr=%h wd=%h", tag, w, a, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h04,  32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'h100, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h20,  32'h11112222, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'hFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'hFC,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h100, 32'h55555555, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h22,  32'h66666666, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11112222, 1'b0};
    vecs[12] = '{1'b0, 32'h04,  32'h0,        4'hF, 32'h0BADF00D, 1'b0};

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; adr = '0; wd = '0; be = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready_a", 32'(ready_a), 32'd0);
    check("reset err_a", 32'(err_a), 32'd0);
    check("reset rd_a", rd_a, 32'd0);
    check("reset ready_b", 32'(ready_b), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      txn(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].exp_rd, vecs[i].exp_err,
          $sformatf("vec%0d", i));
    end

    // Reset while BUSY: write must be abandoned and ready must never appear.
    @(negedge clk);
    we = 1'b1; adr = 32'h20; wd = 32'h12345678; be = 4'hF; req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0;
    check("busy-reset ready", 32'(ready_a), 32'd0);
    check("busy-reset err", 32'(err_a), 32'd0);
    check("busy-reset rd", rd_a, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("busy-reset quiet%0d", i), 32'(ready_a), 32'd0);
    end
    $display("txn busy-reset write 0x20 aborted");
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11112222, 1'b0, "after-busy-reset rd20");

    // Reset during RESP of a write: the committing edge is suppressed.
    @(negedge clk);
    we = 1'b1; adr = 32'h10; wd = 32'hAAAA5555; be = 4'hF; req_a = 1'b1;
    @(posedge clk);
    repeat (WAIT_A + 1) @(negedge clk);
    check("resp-reset ready before", 32'(ready_a), 32'd1);
    reset = 1'b1; req_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("resp-reset ready after", 32'(ready_a), 32'd0);
    $display("txn resp-reset write 0x10 aborted");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "after-resp-reset rd10");

    // Zero wait states: req held high gives a ready pulse every second cycle.
    txn(1'b1, 1'b1, 32'h04, 32'h13579BDF, 4'hF, 32'h0, 1'b0, "w0 wr04");
    @(negedge clk);
    we = 1'b0; adr = 32'h04; req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("w0 burst ready%0d", i), 32'(ready_b), 32'((i % 2) == 0));
      if (ready_b) check($sformatf("w0 burst rd%0d", i), rd_b, 32'h13579BDF);
      if (i == 7) req_b = 1'b0;
      $display("txn w0 burst cycle %0d ready=%0d rd=%h", i, ready_b, rd_b);
    end
    @(negedge clk);

`ifdef MEMRESP_BYTE_EN
    txn(1'b0, 1'b1, 32'h00, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b0, "be full");
    txn(1'b0, 1'b1, 32'h00, 32'h00000000, 4'b0101, 32'h0,        1'b0, "be 0101");
    txn(1'b0, 1'b0, 32'h00, 32'h0,        4'h0,    32'hFF00FF00, 1'b0, "be rd0");
    txn(1'b0, 1'b1, 32'h00, 32'h12345678, 4'h0,    32'h0,        1'b0, "be none");
    txn(1'b0, 1'b0, 32'h00, 32'h0,        4'hF,    32'hFF00FF00, 1'b0, "be rd0 again");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
